// File: rtl/mem_bist_pkg.sv
// Shared types and the address-derived test pattern for the memory BIST engine.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } bist_state_e;

  // Wide arithmetic so any data width up to 64 can truncate the result.
  function automatic logic [63:0] bist_pattern(input logic [31:0] addr,
                                               input logic        pass_sel,
                                               input logic [63:0] seed,
                                               input logic [31:0] stride);
    logic [63:0] p;
    p = seed + (64'(addr) * 64'(stride));
    return pass_sel ? ~p : p;
  endfunction

endpackage

// File: rtl/mem_bist_ctrl_if.sv
// Control/status and memory-side bus of the BIST engine.
interface mem_bist_ctrl_if #(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [AddrWidth+1:0] fail_count;
  logic [AddrWidth-1:0] first_fail_addr;
  logic                 mem_wr;
  logic                 mem_rd;
  logic [AddrWidth-1:0] mem_addr;
  logic [DataWidth-1:0] mem_wdata;
  logic [DataWidth-1:0] mem_rdata;

  modport master (
    input  start, mem_rdata,
    output busy, done, pass, fail_count, first_fail_addr,
    output mem_wr, mem_rd, mem_addr, mem_wdata
  );

  modport slave (
    output start, mem_rdata,
    input  busy, done, pass, fail_count, first_fail_addr,
    input  mem_wr, mem_rd, mem_addr, mem_wdata
  );
endinterface

// File: rtl/bist_cmp_pipe.sv
// Delays expected data/address by the memory read latency and compares against read data.
module bist_cmp_pipe #(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Latency   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [DataWidth-1:0] exp_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 mismatch_o,
  output logic [AddrWidth-1:0] addr_o
);

  logic                 valid_q [Latency];
  logic [DataWidth-1:0] exp_q   [Latency];
  logic [AddrWidth-1:0] addr_q  [Latency];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Latency; i++) begin
        valid_q[i] <= 1'b0;
        exp_q[i]   <= '0;
        addr_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      exp_q[0]   <= exp_i;
      addr_q[0]  <= addr_i;
      for (int i = 1; i < Latency; i++) begin
        valid_q[i] <= valid_q[i-1];
        exp_q[i]   <= exp_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign mismatch_o = valid_q[Latency-1] && (rdata_i != exp_q[Latency-1]);
  assign addr_o     = addr_q[Latency-1];

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-style BIST: write pattern, read/compare, repeat inverted; reports pass and fail stats.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MemSize   = 32,
  parameter int unsigned RdLatency = 1,
  parameter logic [31:0] Seed      = 32'h100,
  parameter int unsigned Stride    = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_bist_ctrl_if.master bus_io
);

  localparam int unsigned DrainW = (RdLatency > 1) ? $clog2(RdLatency) : 1;
  localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(MemSize - 1);
  localparam logic [DrainW-1:0]    LastDrain = DrainW'(RdLatency - 1);

  bist_state_e          state_q;
  logic                 pass_sel_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic                 wr_q;
  logic                 rd_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic [AddrWidth+1:0] fail_cnt_q;
  logic [AddrWidth-1:0] first_fail_q;
  logic [DrainW-1:0]    drain_cnt_q;

  logic [AddrWidth-1:0] addr_inc;
  logic [DataWidth-1:0] wr_next;
  logic [DataWidth-1:0] wr_first0;
  logic [DataWidth-1:0] wr_first1;
  logic [DataWidth-1:0] rd_exp;
  logic                 cmp_mis;
  logic [AddrWidth-1:0] cmp_addr;

  always_comb begin
    addr_inc  = addr_q + 1'b1;
    wr_next   = DataWidth'(bist_pattern(32'(addr_inc), pass_sel_q, 64'(Seed), 32'(Stride)));
    wr_first0 = DataWidth'(bist_pattern(32'd0, 1'b0, 64'(Seed), 32'(Stride)));
    wr_first1 = DataWidth'(bist_pattern(32'd0, 1'b1, 64'(Seed), 32'(Stride)));
    rd_exp    = DataWidth'(bist_pattern(32'(addr_q), pass_sel_q, 64'(Seed), 32'(Stride)));
  end

  // Expected data tracks the address currently on the bus while mem_rd is high.
  bist_cmp_pipe #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth),
    .Latency   (RdLatency)
  ) u_cmp_pipe (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (rd_q),
    .exp_i      (rd_exp),
    .addr_i     (addr_q),
    .rdata_i    (bus_io.mem_rdata),
    .mismatch_o (cmp_mis),
    .addr_o     (cmp_addr)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pass_sel_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      drain_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (cmp_mis) begin
        if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + 1'b1;
        if (fail_cnt_q == '0) first_fail_q <= cmp_addr;
      end
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            state_q      <= StWrite;
            pass_sel_q   <= 1'b0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
            wr_q         <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= wr_first0;
          end
        end
        StWrite: begin
          if (addr_q == LastAddr) begin
            state_q <= StRead;
            wr_q    <= 1'b0;
            rd_q    <= 1'b1;
            addr_q  <= '0;
          end else begin
            addr_q  <= addr_inc;
            wdata_q <= wr_next;
          end
        end
        StRead: begin
          if (addr_q == LastAddr) begin
            state_q     <= StDrain;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            drain_cnt_q <= '0;
          end else begin
            addr_q <= addr_inc;
          end
        end
        StDrain: begin
          if (drain_cnt_q == LastDrain) begin
            if (pass_sel_q) begin
              state_q <= StDone;
            end else begin
              state_q    <= StWrite;
              pass_sel_q <= 1'b1;
              wr_q       <= 1'b1;
              addr_q     <= '0;
              wdata_q    <= wr_first1;
            end
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b1;
          pass_q  <= (fail_cnt_q == '0);
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.busy            = busy_q;
  assign bus_io.done            = done_q;
  assign bus_io.pass            = pass_q;
  assign bus_io.fail_count      = fail_cnt_q;
  assign bus_io.first_fail_addr = first_fail_q;
  assign bus_io.mem_wr          = wr_q;
  assign bus_io.mem_rd          = rd_q;
  assign bus_io.mem_addr        = addr_q;
  assign bus_io.mem_wdata       = wdata_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with a latency-1 memory model and injectable faults.
module tb_mem_bist_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MS = 32;
  localparam int RL = 1;
  localparam int RunCycles = 2 * (2 * MS + RL) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bist_ctrl_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

  mem_bist_ctrl #(
    .AddrWidth (AW),
    .DataWidth (DW),
    .MemSize   (MS),
    .RdLatency (RL),
    .Seed      (32'h100),
    .Stride    (3)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  // 0: clean, 1: bit0 stuck-at-0 at addr 5, 2: read data inverted at addr 7 and 20
  int fault_mode = 0;
  logic [DW-1:0] mem [MS];

  always @(posedge clk) begin
    if (bus.mem_wr)
      mem[bus.mem_addr] <= (fault_mode == 1 && bus.mem_addr == 5) ?
                           (bus.mem_wdata & ~32'h1) : bus.mem_wdata;
    if (bus.mem_rd)
      bus.mem_rdata <= (fault_mode == 2 && (bus.mem_addr == 7 || bus.mem_addr == 20)) ?
                       ~mem[bus.mem_addr] : mem[bus.mem_addr];
  end

  int total = 0;
  int bad = 0;
  int cycles;
  int done_pulses;
  logic both_strobes;
  logic busy_at1;
  logic [DW-1:0] wd0;
  logic [DW-1:0] wd1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a run and watch it; cycles = edges after the start-sampling edge until done.
  task automatic run(input int repulse_at, input bit hold_start);
    cycles = 0;
    done_pulses = 0;
    both_strobes = 1'b0;
    busy_at1 = 1'b0;
    wd0 = '0;
    wd1 = '0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = hold_start;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = hold_start || (c == repulse_at);
      if (c == 1) busy_at1 = bus.busy;
      if (bus.mem_wr && bus.mem_rd) both_strobes = 1'b1;
      if (bus.mem_wr && bus.mem_addr == 5'd3) begin
        if (c < RunCycles / 2) wd0 = bus.mem_wdata;
        else wd1 = bus.mem_wdata;
      end
      if (bus.done) begin
        done_pulses++;
        if (cycles == 0) cycles = c;
        if (hold_start) break;
      end
      if (cycles != 0 && c >= cycles + 5) break;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_pass", bus.pass, 0);
    check("rst_fail_count", bus.fail_count, 0);
    check("rst_first_fail", bus.first_fail_addr, 0);
    check("rst_mem_wr", bus.mem_wr, 0);
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    rst = 1'b0;

    // Clean run: timing, bus pattern, results.
    fault_mode = 0;
    run(0, 1'b0);
    check("clean_cycles", cycles, RunCycles);
    check("clean_busy_at1", busy_at1, 1);
    check("clean_done_pulses", done_pulses, 1);
    check("clean_no_both_strobes", both_strobes, 0);
    check("clean_wdata_p0_a3", wd0, 32'h0000_0109);
    check("clean_wdata_p1_a3", wd1, 32'hFFFF_FEF6);
    check("clean_pass", bus.pass, 1);
    check("clean_fail_count", bus.fail_count, 0);
    check("clean_first_fail", bus.first_fail_addr, 0);
    check("clean_busy_after", bus.busy, 0);

    // Stuck-at-0 on bit 0 of addr 5: only the pass-0 pattern exposes it.
    fault_mode = 1;
    run(0, 1'b0);
    check("stuck_cycles", cycles, RunCycles);
    check("stuck_pass", bus.pass, 0);
    check("stuck_fail_count", bus.fail_count, 1);
    check("stuck_first_fail", bus.first_fail_addr, 5);

    // Inverted reads at 7 and 20 fail in both passes.
    fault_mode = 2;
    run(0, 1'b0);
    check("inv_pass", bus.pass, 0);
    check("inv_fail_count", bus.fail_count, 4);
    check("inv_first_fail", bus.first_fail_addr, 7);

    // start re-pulsed during READ is ignored.
    run(40, 1'b0);
    check("repulse_cycles", cycles, RunCycles);
    check("repulse_done_pulses", done_pulses, 1);
    check("repulse_fail_count", bus.fail_count, 4);
    check("repulse_first_fail", bus.first_fail_addr, 7);

    // Reset mid-WRITE aborts at once.
    fault_mode = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("midrun_mem_wr", bus.mem_wr, 1);
    rst = 1'b1;
    #1;
    check("abort_mem_wr", bus.mem_wr, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_mem_addr", bus.mem_addr, 0);
    check("abort_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 1'b0);
    check("after_abort_cycles", cycles, RunCycles);
    check("after_abort_pass", bus.pass, 1);
    check("after_abort_fail_count", bus.fail_count, 0);

    // start held high through DONE launches a new run straight away.
    run(0, 1'b1);
    check("hold_cycles", cycles, RunCycles);
    @(negedge clk);
    check("hold_restart_busy", bus.busy, 1);
    bus.start = 1'b0;
    cycles = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        cycles = c;
        break;
      end
    end
    check("hold_second_done_seen", cycles != 0, 1);
    check("hold_second_pass", bus.pass, 1);
    check("hold_second_fail_count", bus.fail_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
